fu_cdb_arbiter: RTL

- Completion arbiter between the functional units (ALU lanes, pipelined mult, branch unit) and the common data bus (CDB).
- Each FU owns one holding slot; up to CDB_WIDTH held results broadcast per cycle, round-robin across FUs.
- Back-pressure to the issue stage via fu_ready; holding slots track branch masks (squash on recovery, bit clear on resolve), like every in-flight FU entry.

---
 rtl/fu_cdb_arbiter_pkg.sv | 34 +++
 rtl/fu_cdb_arbiter_rr_multi_grant.sv | 35 +++
 rtl/fu_cdb_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/fu_cdb_arbiter_pkg.sv
// fu_cdb_arbiter_pkg: shared completion-entry type and branch-mask helpers
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BRANCH_STACK_SIZE
`define BRANCH_STACK_SIZE 4
`endif

package fu_cdb_arbiter_pkg;
  localparam int BSS        = `BRANCH_STACK_SIZE;
  localparam int PRN_W      = 6;
  localparam int ROB_W      = 5;
  localparam int ALU_FUNC_W = 4;

  typedef struct packed {
    logic                  valid;
    logic [`XLEN-1:0]      result;
    logic [PRN_W-1:0]      dest_prn;
    logic [ROB_W-1:0]      rob_idx;
    logic [BSS-1:0]        branch_mask;
    logic [ALU_FUNC_W-1:0] alu_function;
  } FU_DONE_ENTRY;

  function automatic logic squash_hit(logic [BSS-1:0] mask, logic recovery, logic [BSS-1:0] stack);
    return recovery && |(mask & stack);
  endfunction

  function automatic FU_DONE_ENTRY clear_mask(FU_DONE_ENTRY e, logic correct, logic [BSS-1:0] stack);
    FU_DONE_ENTRY r;
    r = e;
    if (correct) r.branch_mask = e.branch_mask & ~stack;
    return r;
  endfunction
endpackage

// File: rtl/fu_cdb_arbiter_rr_multi_grant.sv
// rr_multi_grant: round-robin scan from a pointer granting up to CDB_WIDTH eligible requesters
module rr_multi_grant #(
  parameter int NUM_FU    = 4,
  parameter int CDB_WIDTH = 2,
  parameter int IDX_W     = $clog2(NUM_FU)
) (
  input  logic [NUM_FU-1:0]                 i_elig,
  input  logic [IDX_W-1:0]                  i_rr_ptr,
  output logic [NUM_FU-1:0]                 o_grant,
  output logic [CDB_WIDTH-1:0]              o_port_valid,
  output logic [CDB_WIDTH-1:0][IDX_W-1:0]   o_port_idx,
  output logic [IDX_W-1:0]                  o_next_ptr
);
  // walk FUs in rotated order; the n-th eligible one found lands on port n
  always_comb begin
    int n;
    n = 0;
    o_grant      = '0;
    o_port_valid = '0;
    o_port_idx   = '0;
    o_next_ptr   = i_rr_ptr;
    for (int k = 0; k < NUM_FU; k++)
      for (int f = 0; f < NUM_FU; f++)
        if (f == (int'(i_rr_ptr) + k) % NUM_FU && i_elig[f] && n < CDB_WIDTH) begin
          o_grant[f] = 1'b1;
          for (int p = 0; p < CDB_WIDTH; p++)
            if (p == n) begin
              o_port_valid[p] = 1'b1;
              o_port_idx[p]   = IDX_W'(f);
            end
          o_next_ptr = IDX_W'((f + 1) % NUM_FU);
          n++;
        end
  end
endmodule

// File: rtl/fu_cdb_arbiter.sv
// fu_cdb_arbiter: one holding slot per FU, up to CDB_WIDTH round-robin broadcasts per cycle
module fu_cdb_arbiter
  import fu_cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU    = 4,
  parameter int CDB_WIDTH = 2,
  localparam int IDX_W    = $clog2(NUM_FU)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_FU-1:0]                 i_fu_valid,
  input  FU_DONE_ENTRY [NUM_FU-1:0]         i_fu_entry,
  input  logic                              i_branch_recovery,
  input  logic                              i_branch_correct,
  input  logic [BSS-1:0]                    i_branch_stack,
  output logic [NUM_FU-1:0]                 o_fu_ready,
  output logic [CDB_WIDTH-1:0]              o_cdb_valid,
  output FU_DONE_ENTRY [CDB_WIDTH-1:0]      o_cdb_entry,
  output logic [CDB_WIDTH-1:0][IDX_W-1:0]   o_cdb_fu_idx
);
  logic [NUM_FU-1:0]        r_hold_valid;
  FU_DONE_ENTRY [NUM_FU-1:0] r_hold_entry;
  logic [IDX_W-1:0]         r_rr_ptr;
  logic [NUM_FU-1:0]        w_squash, w_in_squash, w_elig, w_grant;
  logic [IDX_W-1:0]         w_next_ptr;

  // squash held and incoming entries whose mask hits the mispredicted branch
  always_comb begin
    w_squash    = '0;
    w_in_squash = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_squash[i]    = squash_hit(r_hold_entry[i].branch_mask, i_branch_recovery, i_branch_stack);
      w_in_squash[i] = squash_hit(i_fu_entry[i].branch_mask, i_branch_recovery, i_branch_stack);
    end
  end

  assign w_elig     = r_hold_valid & ~w_squash;
  assign o_fu_ready = ~r_hold_valid | w_grant | w_squash;

  rr_multi_grant #(.NUM_FU(NUM_FU), .CDB_WIDTH(CDB_WIDTH), .IDX_W(IDX_W)) u_grant (
    .i_elig       (w_elig),
    .i_rr_ptr     (r_rr_ptr),
    .o_grant      (w_grant),
    .o_port_valid (o_cdb_valid),
    .o_port_idx   (o_cdb_fu_idx),
    .o_next_ptr   (w_next_ptr)
  );

  // broadcast payload; a resolving-correct branch is cleared from the mask on the way out
  always_comb begin
    o_cdb_entry = '0;
    for (int k = 0; k < CDB_WIDTH; k++)
      if (o_cdb_valid[k])
        o_cdb_entry[k] = clear_mask(r_hold_entry[o_cdb_fu_idx[k]], i_branch_correct, i_branch_stack);
  end

  // refill freed slots, keep masks of waiting entries current, advance the pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hold_valid <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_rr_ptr <= w_next_ptr;
      for (int i = 0; i < NUM_FU; i++)
        if (o_fu_ready[i]) begin
          r_hold_valid[i] <= i_fu_valid[i] && !w_in_squash[i];
          r_hold_entry[i] <= clear_mask(i_fu_entry[i], i_branch_correct, i_branch_stack);
        end else
          r_hold_entry[i] <= clear_mask(r_hold_entry[i], i_branch_correct, i_branch_stack);
    end
  end

  // branch control must be exclusive and one-hot, and ports must never share a source
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(i_branch_recovery && i_branch_correct));
      assert (!(i_branch_recovery || i_branch_correct) || $onehot(i_branch_stack));
      for (int j = 0; j < CDB_WIDTH; j++)
        for (int k = j + 1; k < CDB_WIDTH; k++)
          assert (!(o_cdb_valid[j] && o_cdb_valid[k] && o_cdb_fu_idx[j] == o_cdb_fu_idx[k]));
    end
  end
endmodule
